sumador_sat_acum: RTL and testbench

SUMADOR_SAT_ACUM -- requirements
Module: sumador_sat_acum

---
 rtl/sumador_sat_acum_pkg.sv | 20 ++
 rtl/sumador_sat.sv | 29 ++
 rtl/sumador_sat_acum.sv | 177 +++++++++++++++++
 tb/tb_sumador_sat_acum.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sumador_sat_acum_pkg.sv
// rtl/sumador_sat_acum_pkg.sv - shared constants: default width, op encodings, channel index width
package sumador_sat_acum_pkg;

  // Base width unit; the default operand width is twice this.
  localparam int N     = 8;
  localparam int W_DEF = 2 * N;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  // Channel index width, never narrower than one bit.
  function automatic int ch_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/sumador_sat.sv
// rtl/sumador_sat.sv - combinational W+1-bit add/subtract with signed saturation
module sumador_sat #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y,
  output logic         sat
);

  logic [W:0] w_ext_a;
  logic [W:0] w_ext_b;
  logic [W:0] w_sum;

  assign w_ext_a = {a[W-1], a};
  assign w_ext_b = {b[W-1], b};
  assign w_sum   = sub ? (w_ext_a - w_ext_b) : (w_ext_a + w_ext_b);

  // Clamp when the guard bit disagrees with the result sign bit.
  always_comb begin
    sat = w_sum[W] ^ w_sum[W-1];
    y   = w_sum[W-1:0];
    if (sat) begin
      y = w_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/sumador_sat_acum.sv
// rtl/sumador_sat_acum.sv - two-stage saturating adder with per-channel accumulators
module sumador_sat_acum
  import sumador_sat_acum_pkg::*;
#(
  parameter int  W   = W_DEF,
  parameter int  CH  = 4,
  localparam int CHW = ch_width(CH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_op,
  input  logic [CHW-1:0] in_ch,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [CHW-1:0] out_ch,
  output logic           out_sat,
  output logic [CH-1:0]  sat_flags,
  input  logic [CH-1:0]  flag_clr
);

  logic           r_init;
  logic [W-1:0]   r_acc [CH];
  logic           r_s1_valid;
  logic [W-1:0]   r_s1_data;
  logic [CHW-1:0] r_s1_ch;
  logic           r_s1_sat;
  logic           r_s1_flag;

  op_e            w_op;
  logic           w_en;
  logic           w_accept;
  logic           w_ch_ok;
  logic [W-1:0]   w_acc_sel;
  logic [W-1:0]   w_add_a;
  logic [W-1:0]   w_add_b;
  logic           w_sub;
  logic [W-1:0]   w_sum;
  logic           w_sum_sat;
  logic [W-1:0]   w_res;
  logic           w_res_sat;
  logic           w_res_flag;
  logic           w_acc_we;
  logic [CH-1:0]  w_set_mask;

  assign w_op     = op_e'(in_op);
  assign w_en     = !out_valid || out_ready;
  assign in_ready = r_init && w_en;
  assign w_accept = in_valid && in_ready;
  assign w_ch_ok  = int'(in_ch) < CH;

  // Read the addressed accumulator; out-of-range channels read as zero.
  always_comb begin
    w_acc_sel = '0;
    for (int i = 0; i < CH; i++) begin
      if (int'(in_ch) == i) w_acc_sel = r_acc[i];
    end
  end

  // Steer operands into the single shared adder.
  always_comb begin
    w_add_a = in_a;
    w_add_b = in_b;
    w_sub   = 1'b0;
    case (w_op)
      OP_SUB:  w_sub = 1'b1;
      OP_ACC: begin
        w_add_a = w_acc_sel;
        w_add_b = in_a;
      end
      default: ;
    endcase
  end

  sumador_sat #(.W(W)) u_sumador_sat (
    .a   (w_add_a),
    .b   (w_add_b),
    .sub (w_sub),
    .y   (w_sum),
    .sat (w_sum_sat)
  );

  // Pick the stage-1 result; LOAD bypasses the adder and bad channels give zero.
  always_comb begin
    w_res      = w_sum;
    w_res_sat  = w_sum_sat;
    w_res_flag = w_sum_sat && w_ch_ok;
    w_acc_we   = 1'b0;
    case (w_op)
      OP_ACC: begin
        if (w_ch_ok) begin
          w_acc_we = 1'b1;
        end else begin
          w_res      = '0;
          w_res_sat  = 1'b0;
          w_res_flag = 1'b0;
        end
      end
      OP_LOAD: begin
        w_res_sat  = 1'b0;
        w_res_flag = 1'b0;
        if (w_ch_ok) begin
          w_res    = in_a;
          w_acc_we = 1'b1;
        end else begin
          w_res = '0;
        end
      end
      default: ;
    endcase
  end

  // Flag bit to set as the stage-1 result moves into the output register.
  always_comb begin
    w_set_mask = '0;
    for (int i = 0; i < CH; i++) begin
      if (w_en && r_s1_valid && r_s1_flag && (int'(r_s1_ch) == i)) w_set_mask[i] = 1'b1;
    end
  end

  // Hold off acceptance until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_init <= 1'b0;
    else        r_init <= 1'b1;
  end

  // Stage 1: capture the saturated result and write the accumulator at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_ch    <= '0;
      r_s1_sat   <= 1'b0;
      r_s1_flag  <= 1'b0;
      for (int i = 0; i < CH; i++) r_acc[i] <= '0;
    end else if (w_en) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data <= w_res;
        r_s1_ch   <= in_ch;
        r_s1_sat  <= w_res_sat;
        r_s1_flag <= w_res_flag;
        for (int i = 0; i < CH; i++) begin
          if (w_acc_we && (int'(in_ch) == i)) r_acc[i] <= w_res;
        end
      end
    end
  end

  // Stage 2: output register, frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_sat   <= 1'b0;
    end else if (w_en) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_data <= r_s1_data;
        out_ch   <= r_s1_ch;
        out_sat  <= r_s1_sat;
      end
    end
  end

  // Sticky saturation flags; a same-cycle set overrides the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_flags <= '0;
    else        sat_flags <= (sat_flags & ~flag_clr) | w_set_mask;
  end

endmodule

// File: tb/tb_sumador_sat_acum.sv
// tb/tb_sumador_sat_acum.sv - self-checking bench for sumador_sat_acum
module tb_sumador_sat_acum;

  localparam int W   = 16;
  localparam int CH  = 4;
  localparam int CHW = 2;

  localparam logic [1:0] ADD  = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] LOAD = 2'd3;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           in_valid  = 1'b0;
  logic           in_ready;
  logic [1:0]     in_op     = '0;
  logic [CHW-1:0] in_ch     = '0;
  logic [W-1:0]   in_a      = '0;
  logic [W-1:0]   in_b      = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_data;
  logic [CHW-1:0] out_ch;
  logic           out_sat;
  logic [CH-1:0]  sat_flags;
  logic [CH-1:0]  flag_clr  = '0;

  int n_vec = 0;
  int n_err = 0;

  longint        macc [CH];
  logic [CH-1:0] mflags = '0;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  ch;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_d;
    logic        exp_s;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  ch;
    logic        s;
  } exp_t;

  sumador_sat_acum #(.W(W), .CH(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_ch     (in_ch),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_sat   (out_sat),
    .sat_flags (sat_flags),
    .flag_clr  (flag_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer result, then clamp to the signed 16-bit range.
  function automatic exp_t model(input logic [1:0] op, input logic [1:0] ch,
                                 input logic [15:0] a, input logic [15:0] b);
    longint x = longint'($signed(a));
    longint y = longint'($signed(b));
    longint r;
    exp_t   e;
    case (op)
      ADD:     r = x + y;
      SUB:     r = x - y;
      ACC:     r = macc[ch] + x;
      default: r = x;
    endcase
    e.s = 1'b0;
    if (r > 32767) begin
      r = 32767;
      e.s = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      e.s = 1'b1;
    end
    e.d  = 16'(r);
    e.ch = ch;
    if (op == ACC || op == LOAD) macc[ch] = r;
    if (e.s) mflags[ch] = 1'b1;
    return e;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flag_clr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < CH; i++) macc[i] = 0;
    mflags = '0;
    @(negedge clk);
  endtask

  task automatic apply(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = v.op;
    in_ch     = v.ch;
    in_a      = v.a;
    in_b      = v.b;
    out_ready = 1'b1;
    #1;
    chk($sformatf("vec%0d_in_ready", idx), in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), lat, 2);
    chk($sformatf("vec%0d_data", idx), out_data, v.exp_d);
    chk($sformatf("vec%0d_sat", idx), out_sat, v.exp_s);
    chk($sformatf("vec%0d_ch", idx), out_ch, v.ch);
  endtask

  // mode 0: consumer always ready; 1: three-cycle stall on a full pipe; 2: random backpressure
  task automatic run_stream(input int ncyc, input int mode);
    exp_t        q[$];
    exp_t        e;
    logic        pv, pr, ps;
    logic [15:0] pd;
    logic [1:0]  pc;
    pv = 1'b0;
    pr = 1'b1;
    pd = '0;
    pc = '0;
    ps = 1'b0;
    for (int c = 0; c < ncyc + 200; c++) begin
      @(negedge clk);
      if (c < ncyc) begin
        in_valid = 1'b1;
        in_op    = 2'($urandom_range(0, 3));
        in_ch    = 2'($urandom_range(0, 3));
        in_a     = rnd16();
        in_b     = rnd16();
      end else begin
        in_valid = 1'b0;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(c >= 4 && c < 7);
        default: out_ready = ($urandom_range(0, 3) != 0) || (c >= ncyc);
      endcase
      #1;
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
        chk("hold_ch", out_ch, pc);
        chk("hold_sat", out_sat, ps);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          chk("stream_data", out_data, e.d);
          chk("stream_ch", out_ch, e.ch);
          chk("stream_sat", out_sat, e.s);
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_op, in_ch, in_a, in_b));
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      pc = out_ch;
      ps = out_sat;
      if (c >= ncyc && q.size() == 0) break;
    end
    chk("stream_drained", q.size(), 0);
    @(negedge clk);
    chk("stream_flags", sat_flags, mflags);
  endtask

  vec_t        tbl [12];
  vec_t        seq [4];
  logic [15:0] seq_exp [4];
  vec_t        v;

  initial begin
    tbl[0]  = '{ADD,  2'd0, 16'h7000, 16'h2000, 16'h7FFF, 1'b1};
    tbl[1]  = '{SUB,  2'd0, 16'h8000, 16'h0001, 16'h8000, 1'b1};
    tbl[2]  = '{SUB,  2'd0, 16'h8000, 16'h8000, 16'h0000, 1'b0};
    tbl[3]  = '{ADD,  2'd0, 16'h1234, 16'h0011, 16'h1245, 1'b0};
    tbl[4]  = '{ADD,  2'd0, 16'h8000, 16'hFFFF, 16'h8000, 1'b1};
    tbl[5]  = '{SUB,  2'd0, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1};
    tbl[6]  = '{SUB,  2'd0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0};
    tbl[7]  = '{LOAD, 2'd3, 16'h8000, 16'h7FFF, 16'h8000, 1'b0};
    tbl[8]  = '{ACC,  2'd3, 16'hFFFF, 16'h0000, 16'h8000, 1'b1};
    tbl[9]  = '{ACC,  2'd3, 16'h0001, 16'h0000, 16'h8001, 1'b0};
    tbl[10] = '{LOAD, 2'd0, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b0};
    tbl[11] = '{ACC,  2'd0, 16'h0001, 16'h0000, 16'h7FFF, 1'b1};

    seq[0] = '{LOAD, 2'd2, 16'h0100, 16'h0000, 16'h0000, 1'b0};
    seq[1] = '{ACC,  2'd2, 16'h0010, 16'h0000, 16'h0000, 1'b0};
    seq[2] = '{ACC,  2'd2, 16'h0010, 16'h0000, 16'h0000, 1'b0};
    seq[3] = '{ACC,  2'd2, 16'h0010, 16'h0000, 16'h0000, 1'b0};
    seq_exp[0] = 16'h0100;
    seq_exp[1] = 16'h0110;
    seq_exp[2] = 16'h0120;
    seq_exp[3] = 16'h0130;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sat_flags", sat_flags, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_first_edge", in_ready, 0);
    @(negedge clk);
    chk("in_ready_after_first_edge", in_ready, 1);

    for (int i = 0; i < 12; i++) apply(tbl[i], i);

    // back-to-back LOAD/ACC on one channel
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk($sformatf("b2b%0d_valid", k - 2), out_valid, 1);
        chk($sformatf("b2b%0d_data", k - 2), out_data, seq_exp[k - 2]);
      end
      if (k < 4) begin
        in_valid = 1'b1;
        in_op    = seq[k].op;
        in_ch    = seq[k].ch;
        in_a     = seq[k].a;
        in_b     = seq[k].b;
      end else begin
        in_valid = 1'b0;
      end
    end

    // saturating ACC with a simultaneous clear: set wins, a lone clear later empties the flag
    v = '{LOAD, 2'd1, 16'h7FF0, 16'h0000, 16'h7FF0, 1'b0};
    apply(v, 100);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = ACC;
    in_ch    = 2'd1;
    in_a     = 16'h0100;
    flag_clr = 4'b0010;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("accsat_valid", out_valid, 1);
    chk("accsat_data", out_data, 16'h7FFF);
    chk("accsat_sat", out_sat, 1);
    chk("flag1_set_wins", sat_flags[1], 1);
    flag_clr = 4'b0000;
    @(negedge clk);
    chk("flag1_held", sat_flags[1], 1);
    flag_clr = 4'b0010;
    @(negedge clk);
    flag_clr = 4'b0000;
    chk("flag1_cleared", sat_flags[1], 0);
    chk("flag0_untouched", sat_flags[0], 1);

    // reset in mid-stream
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = ADD;
      in_ch    = 2'd0;
      in_a     = 16'h0001;
      in_b     = 16'h0001;
    end
    @(posedge clk);
    #1;
    chk("pre_reset_valid", out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_flags", sat_flags, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v = '{ACC, 2'd0, 16'h0005, 16'h0000, 16'h0005, 1'b0};
    apply(v, 200);

    // streaming against the reference model
    do_reset();
    run_stream(40, 1);
    run_stream(300, 0);
    run_stream(400, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
